// File: rtl/axis_packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_rr_arbiter
// Description : Packet-locked round-robin arbiter. It merges CHANNEL_NUMBER
//               AXI-Stream inputs onto one registered output. A grant is held
//               from the first beat of a packet through TLAST, so packets are
//               never interleaved on the output.
//
// Beat vector layout (axis_mosi_t, MOSI_WIDTH bits, LSB first):
//   [0]                      TVALID
//   [1]                      TLAST
//   [2 +: DATA_WIDTH]        TDATA
//   [2+DATA_WIDTH +: ...]    TID, TDEST, TUSER (forwarded untouched)
// axis_miso_t is TREADY only (one bit).
//
// Ports:
//   clk_i       in   clock, single domain
//   rst_n_i     in   synchronous active-low reset
//   in_mosi_i   in   per-channel input beats
//   in_miso_o   out  per-channel input TREADY
//   out_mosi_o  out  registered output beat
//   out_miso_i  in   output TREADY
//   grant_o     out  granted channel index (meaningful while busy_o)
//   busy_o      out  1 while a packet is locked
//   pkt_cnt_o   out  packets completed at the output, wraps
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_rr_arbiter #(
    parameter  int DATA_WIDTH           = 32,
    parameter  int ID_WIDTH             = 0,
    parameter  int DEST_WIDTH           = 0,
    parameter  int USER_WIDTH           = 0,
    parameter  int CHANNEL_NUMBER       = 5,
    parameter  int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter  int PKT_CNT_WIDTH        = 16,
    localparam int MOSI_WIDTH           = 2 + DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [CHANNEL_NUMBER-1:0][MOSI_WIDTH-1:0] in_mosi_i,
    output logic [CHANNEL_NUMBER-1:0]                 in_miso_o,
    output logic [MOSI_WIDTH-1:0]                     out_mosi_o,
    input  logic                                      out_miso_i,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]           grant_o,
    output logic                                      busy_o,
    output logic [PKT_CNT_WIDTH-1:0]                  pkt_cnt_o
);

    // One extra bit so (last_grant + offset) can be wrapped without overflow.
    localparam int                c_SW        = CHANNEL_NUMBER_WIDTH + 1;
    localparam logic [c_SW-1:0]   c_N         = c_SW'(CHANNEL_NUMBER);
    localparam logic [CHANNEL_NUMBER_WIDTH-1:0] c_LAST_CH = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CHANNEL_NUMBER_WIDTH-1:0] r_grant;
    logic [CHANNEL_NUMBER_WIDTH-1:0] w_grant_nxt;
    logic [CHANNEL_NUMBER_WIDTH-1:0] r_last_grant;
    logic [MOSI_WIDTH-1:0]           r_out_beat;
    logic [PKT_CNT_WIDTH-1:0]        r_pkt_cnt;

    logic                            w_found;
    logic [CHANNEL_NUMBER_WIDTH-1:0] w_sel;
    logic                            w_slice_ready;
    logic                            w_in_hs;
    logic                            w_out_hs;
    logic [MOSI_WIDTH-1:0]           w_in_beat;
    logic [CHANNEL_NUMBER-1:0]       w_in_ready;

    // The slice accepts a beat when empty or when its beat leaves this cycle.
    assign w_slice_ready = !r_out_beat[0] || out_miso_i;
    assign w_out_hs      = r_out_beat[0] && out_miso_i;
    assign w_in_beat     = in_mosi_i[r_grant];

    // Round-robin search: walk offsets N..1 so the smallest offset after
    // last_grant is the one that survives.
    always_comb begin
        logic [c_SW-1:0] v_sum;
        w_found = 1'b0;
        w_sel   = '0;
        v_sum   = '0;
        for (int i = CHANNEL_NUMBER; i >= 1; i--) begin
            v_sum = {1'b0, r_last_grant} + c_SW'(i);
            if (v_sum >= c_N) begin
                v_sum = v_sum - c_N;
            end
            if (in_mosi_i[v_sum[CHANNEL_NUMBER_WIDTH-1:0]][0]) begin
                w_found = 1'b1;
                w_sel   = v_sum[CHANNEL_NUMBER_WIDTH-1:0];
            end
        end
    end

    // Next-state and input-side handshake logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_in_ready  = '0;
        w_in_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_sel;
                end
            end
            ST_LOCKED: begin
                w_in_ready[r_grant] = w_slice_ready;
                w_in_hs             = w_in_beat[0] && w_slice_ready;
                // A TVALID gap on the granted input simply waits here.
                if (w_in_hs && w_in_beat[1]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_CH;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_in_hs && w_in_beat[1]) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output register slice. A reset discards any beat held here.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_out_beat <= '0;
        end else if (w_in_hs) begin
            r_out_beat <= w_in_beat;
        end else if (w_out_hs) begin
            r_out_beat[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pkt_cnt <= '0;
        end else if (w_out_hs && r_out_beat[1]) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign in_miso_o  = w_in_ready;
    assign out_mosi_o = r_out_beat;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state == ST_LOCKED);
    assign pkt_cnt_o  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_rr_arbiter
// Description : Scoreboard bench for axis_packet_rr_arbiter. Stimulus loads
//               per-channel packet queues; a transaction-level round-robin
//               model predicts the output beat order into a scoreboard queue
//               that an independent monitor drains on output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_rr_arbiter;

    localparam int N   = 5;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int DSW = 0;
    localparam int UW  = 3;
    localparam int SBW = IDW + DSW + UW;
    localparam int MW  = 2 + DW + SBW;
    localparam int PCW = 4;
    localparam int CW  = $clog2(N);

    typedef struct {
        logic [MW-1:0] vec;
        int            gap;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0][MW-1:0]   in_mosi;
    logic [N-1:0]           in_miso;
    logic [MW-1:0]          out_mosi;
    logic                   out_ready;
    logic [CW-1:0]          grant;
    logic                   busy;
    logic [PCW-1:0]         pkt_cnt;

    always #5 clk = ~clk;

    axis_packet_rr_arbiter #(
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (IDW),
        .DEST_WIDTH     (DSW),
        .USER_WIDTH     (UW),
        .CHANNEL_NUMBER (N),
        .PKT_CNT_WIDTH  (PCW)
    ) u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_mosi_i  (in_mosi),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_miso_i (out_ready),
        .grant_o    (grant),
        .busy_o     (busy),
        .pkt_cnt_o  (pkt_cnt)
    );

    beat_t          drv_q[N][$];
    int             cur_gap[N];
    logic [MW-1:0]  sb_q[$];
    int             model_last;
    int             ready_pct;
    int             n_vec;
    int             n_fail;
    int             out_hs_total;
    int             phase_id;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] make_beat(input logic [DW-1:0] data, input logic last,
                                                input logic [SBW-1:0] sb);
        return {sb, data, last, 1'b1};
    endfunction

    task automatic drive_update();
        for (int c = 0; c < N; c++) begin
            if (drv_q[c].size() > 0 && cur_gap[c] == 0) in_mosi[c] = drv_q[c][0].vec;
            else                                        in_mosi[c] = '0;
        end
    endtask

    // One clock: sample input handshakes before the edge, advance after it.
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        for (int c = 0; c < N; c++) hs[c] = rst_n && in_mosi[c][0] && in_miso[c];
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (hs[c]) begin
                void'(drv_q[c].pop_front());
                cur_gap[c] = (drv_q[c].size() > 0) ? drv_q[c][0].gap : 0;
            end else if (cur_gap[c] > 0) begin
                cur_gap[c]--;
            end
        end
        out_ready = ($urandom_range(0, 99) < ready_pct);
        drive_update();
    endtask

    function automatic bit all_idle();
        bit idle = (sb_q.size() == 0);
        for (int c = 0; c < N; c++) if (drv_q[c].size() > 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_done(input int bound);
        int k = 0;
        while (!all_idle() && k < bound) begin
            tick();
            k++;
        end
        if (k >= bound) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: %0d beats still expected after %0d cycles", sb_q.size(), bound);
        end
        repeat (2) tick();
    endtask

    task automatic check_reset_values();
        check("rst_out_mosi", 64'(out_mosi), 64'd0);
        check("rst_in_ready", 64'(in_miso),  64'd0);
        check("rst_grant",    64'(grant),    64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    endtask

    // Single-channel packet with arbitration-latency checks; DUT must be idle.
    task automatic directed_pkt(input int c, input int nb, input logic [DW-1:0] base);
        logic [MW-1:0] v;
        for (int b = 0; b < nb; b++) begin
            v = make_beat(base + DW'(b), (b == nb - 1), SBW'(b + 1));
            drv_q[c].push_back('{vec: v, gap: 0});
            sb_q.push_back(v);
        end
        model_last = c;
        ready_pct  = 100;
        out_ready  = 1'b1;
        drive_update();
        check("lat_busy_t0", 64'(busy), 64'd0);
        tick();
        check("lat_busy_t1",  64'(busy),        64'd1);
        check("lat_grant_t1", 64'(grant),       64'(c));
        check("lat_valid_t1", 64'(out_mosi[0]), 64'd0);
        tick();
        check("lat_valid_t2", 64'(out_mosi[0]),         64'd1);
        check("lat_data_t2",  64'(out_mosi[2 +: DW]),   64'(base));
        wait_done(200);
    endtask

    // Every contending channel presents its first beat at once and keeps
    // TVALID high between its own packets, so the order is pure round robin
    // over channels that still have packets left.
    task automatic run_phase(input logic [N-1:0] mask, input int npk_max,
                             input int nb_min, input int nb_max, input int gap_max);
        int            plen[N][$];
        logic [MW-1:0] exp_b[N][$];
        logic [MW-1:0] v;
        int            len;
        int            ch;
        bit            any;
        phase_id++;
        for (int c = 0; c < N; c++) begin
            if (mask[c]) begin
                for (int p = 0; p < $urandom_range(1, npk_max); p++) begin
                    len = $urandom_range(nb_min, nb_max);
                    plen[c].push_back(len);
                    for (int b = 0; b < len; b++) begin
                        v = make_beat({8'(c), 8'(phase_id), 4'(p), 4'(b), 8'($urandom)},
                                      (b == len - 1), SBW'($urandom));
                        drv_q[c].push_back('{vec: v, gap: (b == 0) ? 0 : $urandom_range(0, gap_max)});
                        exp_b[c].push_back(v);
                    end
                end
            end
        end
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 1; i <= N && !any; i++) begin
                ch = (model_last + i) % N;
                if (plen[ch].size() > 0) begin
                    any = 1'b1;
                    len = plen[ch].pop_front();
                    for (int b = 0; b < len; b++) sb_q.push_back(exp_b[ch].pop_front());
                    model_last = ch;
                end
            end
        end
        drive_update();
        wait_done(4000);
    endtask

    // Monitor: scoreboard pop on output handshakes plus protocol checks.
    initial begin
        logic [MW-1:0]  prev_beat;
        logic           prev_stall;
        logic [PCW-1:0] model_cnt;
        logic [MW-1:0]  exp;
        logic [N-1:0]   exp_rdy;
        prev_beat  = '0;
        prev_stall = 1'b0;
        model_cnt  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                model_cnt  = '0;
            end else begin
                check("pkt_cnt", 64'(pkt_cnt), 64'(model_cnt));
                if (prev_stall) check("stall_hold", 64'(out_mosi), 64'(prev_beat));
                exp_rdy = '0;
                if (busy) exp_rdy[grant] = !out_mosi[0] || out_ready;
                check("in_tready", 64'(in_miso), 64'(exp_rdy));
                if (out_mosi[0] && out_ready) begin
                    out_hs_total++;
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL beat: got unexpected %h, expected none", out_mosi);
                    end else begin
                        exp = sb_q.pop_front();
                        check("beat", 64'(out_mosi), 64'(exp));
                        if (exp[1]) model_cnt = model_cnt + 1'b1;
                    end
                end
                prev_stall = out_mosi[0] && !out_ready;
                prev_beat  = out_mosi;
            end
        end
    end

    initial begin
        int       t0;
        logic [MW-1:0] v;
        n_vec        = 0;
        n_fail       = 0;
        out_hs_total = 0;
        phase_id     = 0;
        model_last   = N - 1;
        ready_pct    = 100;
        out_ready    = 1'b1;
        rst_n        = 1'b0;
        in_mosi      = '0;
        for (int c = 0; c < N; c++) cur_gap[c] = 0;

        repeat (3) tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // ch2 alone: 0xA0..0xA2, grant one cycle after TVALID.
        directed_pkt(2, 3, 32'h0000_00A0);
        check("pkt_cnt_first", 64'(pkt_cnt), 64'd1);

        // All channels contending with 2-beat packets.
        run_phase('1, 2, 2, 2, 0);

        // Random subsets, lengths, TVALID gaps and output back-pressure.
        ready_pct = 50;
        for (int r = 0; r < 30; r++) begin
            run_phase(N'($urandom_range(1, (1 << N) - 1)), 3, 1, 4, 3);
        end

        // ch0 single-beat packets: one output beat every two cycles.
        ready_pct = 100;
        out_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            v = make_beat(32'hC0DE_0000 + DW'(p), 1'b1, SBW'(p));
            drv_q[0].push_back('{vec: v, gap: 0});
            sb_q.push_back(v);
        end
        model_last = 0;
        drive_update();
        t0 = out_hs_total;
        for (int k = 0; k < 20 && out_hs_total == t0; k++) tick();
        repeat (2) tick();
        t0 = out_hs_total;
        repeat (20) tick();
        check("throughput_1of2", 64'(out_hs_total - t0), 64'd10);
        wait_done(200);

        // Reset in the middle of a 4-beat packet from ch0.
        for (int b = 0; b < 4; b++) begin
            v = make_beat(32'hD000_0000 + DW'(b), (b == 3), SBW'(b));
            drv_q[0].push_back('{vec: v, gap: 0});
            sb_q.push_back(v);
        end
        drive_update();
        for (int k = 0; k < 50 && sb_q.size() > 2; k++) tick();
        rst_n = 1'b0;
        for (int c = 0; c < N; c++) begin
            drv_q[c].delete();
            cur_gap[c] = 0;
        end
        sb_q.delete();
        drive_update();
        tick();
        check_reset_values();
        rst_n      = 1'b1;
        model_last = N - 1;
        tick();
        directed_pkt(0, 3, 32'h0000_00E0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_packet_rr_arbiter.md
# axis_packet_rr_arbiter

Packet-locked round-robin arbiter that shares one AXI-Stream output among CHANNEL_NUMBER input channels, with a registered output slice. Sits between the per-channel input FIFOs and the routing-algorithm stage of a router plane (request or response). It replaces a purely combinational grant with a sequenced IDLE/LOCKED controller. A grant is held from the first beat of a packet through TLAST, so packets are never interleaved on the output.

## Interface
- DATA_WIDTH, 32, TDATA width (carried in axis_mosi_t)
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 0 unless TID/TDEST/TUSER_PRESENT, sideband widths
- CHANNEL_NUMBER, 5, number of input channels (≥2)
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), grant index width
- PKT_CNT_WIDTH, 16, completed-packet counter width

Ports:
- clk_i  in  1  clock; single clock domain
- rst_n_i  in  1  reset; synchronous, active-low
- in_mosi_i  in  axis_mosi_t[CHANNEL_NUMBER]  input streams (TVALID, TLAST used; all other fields forwarded)
- in_miso_o  out  axis_miso_t[CHANNEL_NUMBER]  input TREADY
- out_mosi_o  out  axis_mosi_t  registered output stream
- out_miso_i  in  axis_miso_t  output TREADY
- grant_o  out  CHANNEL_NUMBER_WIDTH  currently granted channel (valid when busy_o)
- busy_o  out  1  1 = LOCKED
- pkt_cnt_o  out  PKT_CNT_WIDTH  packets completed at output

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - Round-robin search starting at (last_grant+1) mod CHANNEL_NUMBER for the first input with TVALID=1.
  - If found: grant_q <= index, state <= LOCKED.
  - If not found: remain IDLE.
  - All in TREADY = 0.
- LOCKED:
  - in_miso_o[grant_q].TREADY = slice_ready, where slice_ready = !out_valid_q || out_miso_i.TREADY.
  - All other inputs TREADY = 0.
  - An input handshake loads all mosi fields of the granted input into the output register; out_valid_q <= 1.
  - Handshake with TLAST=1: state <= IDLE, last_grant <= grant_q.
  - Granted input deasserting TVALID mid-packet does not release the grant; the FSM waits in LOCKED.
- Output slice:
  - When out handshake occurs and no new beat is loaded, out_valid_q <= 0.
  - Contents are stable while TVALID=1 and TREADY=0.
  - Full-throughput: 1 beat/cycle when out TREADY is held high.
- pkt_cnt_o: increments on each output handshake with TLAST=1; wraps modulo 2^PKT_CNT_WIDTH.
- Ordering: inputs that are not granted never lose data; they only see TREADY=0.

## Timing
- Reset values (cycle after rst_n_i sampled low):
  - state IDLE, out TVALID 0, all in TREADY 0
  - grant_o 0, busy_o 0, pkt_cnt_o 0
  - last_grant = CHANNEL_NUMBER-1, so channel 0 has first priority
- Arbitration latency: TVALID seen in IDLE at cycle t → busy_o=1 and grant_o valid at t+1.
  - First input handshake at t+1 if the slice is empty.
  - out TVALID=1 at t+2.
- Packet gap: the TLAST input handshake at cycle t returns the FSM to IDLE at t+1; next grant at t+2 (one-cycle bubble per packet).
- Simultaneous output drain and input load in the same cycle: register reloads; out TVALID stays 1.
- Reset mid-packet: the output register is discarded and the FSM returns to IDLE.
  - No partial packet is completed.
  - Upstream is responsible for flushing.

## Test plan
- Reset, then only ch2 sends a 3-beat packet (D=0xA0..0xA2) → grant_o=2 one cycle after TVALID; out beats 0xA0,0xA1,0xA2 with TLAST on 0xA2; pkt_cnt_o=1.
- All 5 channels continuously valid, 2-beat packets → grant order 0,1,2,3,4,0; never two packets' beats interleaved; one idle cycle between packets.
- out TREADY toggling 1,0,0,1 during a 4-beat packet → out_mosi_o held stable on stall cycles; no beat duplicated or dropped; granted in TREADY follows slice_ready.
- Granted ch1 drops TVALID for 3 cycles mid-packet while ch3 is valid → grant_o stays 1; ch3 TREADY=0 until after ch1 TLAST; ch3 granted next.
- Single-beat packets back-to-back from ch0 only → grant is re-granted to ch0 each time; 1 beat every 2 cycles; pkt_cnt_o wraps from 0xFFFF to 0 (preload by running 65536 packets, or use PKT_CNT_WIDTH=4: wrap after 16).
- rst_n_i low for one cycle during beat 2 of 4 → next cycle all outputs at reset values; the following packet from ch0 is arbitrated normally.
